// File: rtl/awg_uart_pkg.sv
// rtl/awg_uart_pkg.sv - frame constants, state encoding and command legality for uart_cmd_ctrl
package awg_uart_pkg;

    localparam logic [7:0] SYNC              = 8'hA5;
    localparam logic [7:0] CMD_WRITE_SAMPLES = 8'h10;
    localparam logic [7:0] CMD_SET_REG       = 8'h20;
    localparam logic [7:0] ACK               = 8'h06;
    localparam logic [7:0] NAK               = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_RESP
    } state_t;

    function automatic logic frame_legal(input logic [7:0] cmd, input logic [7:0] len);
        case (cmd)
            CMD_WRITE_SAMPLES: frame_legal = (len >= 8'd2);
            CMD_SET_REG:       frame_legal = (len == 8'd2);
            default:           frame_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_timer.sv
// rtl/uart_rx_timer.sv - inter-byte idle counter, expires after TIMEOUT-1 enabled cycles
module uart_rx_timer #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_limit;

    assign at_limit = (cnt_q == CW'(TIMEOUT - 1));
    assign expired  = enable && at_limit;

    // Saturates at the limit so a stalled frame keeps reporting expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !at_limit) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command frame parser driving sample RAM writes and config register writes
module uart_cmd_ctrl
    import awg_uart_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        from_uart_data,
    input  logic              from_uart_valid,
    input  logic              from_uart_error,
    output logic              from_uart_ready,
    output logic [7:0]        to_uart_data,
    output logic              to_uart_valid,
    output logic              to_uart_error,
    input  logic              to_uart_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              cfg_we,
    output logic [3:0]        cfg_idx,
    output logic [7:0]        cfg_data,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        chk_q, chk_d;
    logic [7:0]        pcnt_q, pcnt_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        sh_idx_q, sh_idx_d;
    logic [7:0]        sh_val_q, sh_val_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              cfg_we_q, cfg_we_d;
    logic [3:0]        cfg_idx_q, cfg_idx_d;
    logic [7:0]        cfg_data_q, cfg_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              rx_ready_q, rx_ready_d;
    logic              busy_q, busy_d;

    logic accept;
    logic in_frame;
    logic expired;

    assign accept   = from_uart_valid && rx_ready_q;
    assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

    uart_rx_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept || !in_frame),
        .enable  (in_frame),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        chk_d       = chk_q;
        pcnt_d      = pcnt_q;
        addr_hi_d   = addr_hi_q;
        addr_d      = addr_q;
        sh_idx_d    = sh_idx_q;
        sh_val_d    = sh_val_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cfg_we_d    = 1'b0;
        cfg_idx_d   = cfg_idx_q;
        cfg_data_d  = cfg_data_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;

        // An errored byte or an idle gap kills the frame; a byte on the expiry cycle wins.
        if (in_frame && ((accept && from_uart_error) || (!accept && expired))) begin
            state_d    = ST_RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = NAK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && !from_uart_error && from_uart_data == SYNC) begin
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (accept) begin
                        cmd_d   = from_uart_data;
                        chk_d   = from_uart_data;
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        len_d   = from_uart_data;
                        chk_d   = chk_q ^ from_uart_data;
                        pcnt_d  = 8'd0;
                        state_d = (from_uart_data != 8'd0) ? ST_PAYLOAD : ST_CHK;
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        chk_d  = chk_q ^ from_uart_data;
                        pcnt_d = pcnt_q + 8'd1;
                        if (cmd_q == CMD_WRITE_SAMPLES) begin
                            if (pcnt_q == 8'd0) begin
                                addr_hi_d = from_uart_data;
                            end else if (pcnt_q == 8'd1) begin
                                addr_d = ADDR_W'({addr_hi_q, from_uart_data});
                            end else begin
                                ram_we_d    = 1'b1;
                                ram_addr_d  = addr_q;
                                ram_wdata_d = from_uart_data;
                                addr_d      = addr_q + ADDR_W'(1);
                            end
                        end
                        if (cmd_q == CMD_SET_REG) begin
                            if (pcnt_q == 8'd0) sh_idx_d = from_uart_data[3:0];
                            if (pcnt_q == 8'd1) sh_val_d = from_uart_data;
                        end
                        if (pcnt_q == len_q - 8'd1) state_d = ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (accept) begin
                        state_d    = ST_RESP;
                        tx_valid_d = 1'b1;
                        if (from_uart_data == chk_q && frame_legal(cmd_q, len_q)) begin
                            tx_data_d = ACK;
                            if (cmd_q == CMD_SET_REG) begin
                                cfg_we_d   = 1'b1;
                                cfg_idx_d  = sh_idx_q;
                                cfg_data_d = sh_val_q;
                            end
                        end else begin
                            tx_data_d = NAK;
                        end
                    end
                end
                ST_RESP: begin
                    if (to_uart_ready) begin
                        state_d    = ST_IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        rx_ready_d = (state_d != ST_RESP);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            len_q       <= '0;
            chk_q       <= '0;
            pcnt_q      <= '0;
            addr_hi_q   <= '0;
            addr_q      <= '0;
            sh_idx_q    <= '0;
            sh_val_q    <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cfg_we_q    <= 1'b0;
            cfg_idx_q   <= '0;
            cfg_data_q  <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            rx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            pcnt_q      <= pcnt_d;
            addr_hi_q   <= addr_hi_d;
            addr_q      <= addr_d;
            sh_idx_q    <= sh_idx_d;
            sh_val_q    <= sh_val_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cfg_we_q    <= cfg_we_d;
            cfg_idx_q   <= cfg_idx_d;
            cfg_data_q  <= cfg_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            rx_ready_q  <= rx_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign from_uart_ready = rx_ready_q;
    assign to_uart_data    = tx_data_q;
    assign to_uart_valid   = tx_valid_q;
    assign to_uart_error   = 1'b0;
    assign ram_we          = ram_we_q;
    assign ram_addr        = ram_addr_q;
    assign ram_wdata       = ram_wdata_q;
    assign cfg_we          = cfg_we_q;
    assign cfg_idx         = cfg_idx_q;
    assign cfg_data        = cfg_data_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - self-checking bench: vector table, random frames vs frame model, corner sequences
module tb_uart_cmd_ctrl;

    localparam int AW = 12;
    localparam int TO = 40;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    from_uart_data;
    logic          from_uart_valid;
    logic          from_uart_error;
    logic          from_uart_ready;
    logic [7:0]    to_uart_data;
    logic          to_uart_valid;
    logic          to_uart_error;
    logic          to_uart_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          cfg_we;
    logic [3:0]    cfg_idx;
    logic [7:0]    cfg_data;
    logic          busy;

    uart_cmd_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .from_uart_data  (from_uart_data),
        .from_uart_valid (from_uart_valid),
        .from_uart_error (from_uart_error),
        .from_uart_ready (from_uart_ready),
        .to_uart_data    (to_uart_data),
        .to_uart_valid   (to_uart_valid),
        .to_uart_error   (to_uart_error),
        .to_uart_ready   (to_uart_ready),
        .ram_we          (ram_we),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .cfg_we          (cfg_we),
        .cfg_idx         (cfg_idx),
        .cfg_data        (cfg_data),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int excl_viol = 0;

    logic [19:0] ram_q[$];
    logic [11:0] cfg_q[$];
    logic [7:0]  resp_q[$];
    logic [19:0] exp_ram[$];
    logic [11:0] exp_cfg[$];
    logic [7:0]  exp_resp;
    logic [7:0]  pl[$];

    always @(negedge clk) begin
        if (ram_we) ram_q.push_back({ram_addr, ram_wdata});
        if (cfg_we) cfg_q.push_back({cfg_idx, cfg_data});
        if (ram_we && cfg_we) excl_viol++;
        if (to_uart_valid && to_uart_ready) resp_q.push_back(to_uart_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        ram_q.delete();
        cfg_q.delete();
        resp_q.delete();
        exp_ram.delete();
        exp_cfg.delete();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic e);
        int w;
        w = 0;
        @(negedge clk);
        from_uart_valid = 1'b1;
        from_uart_data  = d;
        from_uart_error = e;
        while (!from_uart_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("send_byte_ready_wait", 32'(w), 32'd0);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            from_uart_valid = 1'b0;
            from_uart_error = 1'b0;
        end
    endtask

    task automatic wait_resp(input string tag);
        int w;
        w = 0;
        idle(1);
        while (resp_q.size() == 0 && w < 30) begin
            idle(1);
            w++;
        end
        if (w >= 30) chk({tag, "_resp_wait"}, 32'(w), 32'd0);
        idle(2);
    endtask

    task automatic compare_frame(input string tag);
        chk({tag, "_resp_cnt"}, 32'(resp_q.size()), 32'd1);
        if (resp_q.size() > 0) chk({tag, "_resp"}, 32'(resp_q[0]), 32'(exp_resp));
        chk({tag, "_ram_cnt"}, 32'(ram_q.size()), 32'(exp_ram.size()));
        for (int i = 0; i < ram_q.size() && i < exp_ram.size(); i++)
            chk({tag, "_ram_wr"}, 32'(ram_q[i]), 32'(exp_ram[i]));
        chk({tag, "_cfg_cnt"}, 32'(cfg_q.size()), 32'(exp_cfg.size()));
        for (int i = 0; i < cfg_q.size() && i < exp_cfg.size(); i++)
            chk({tag, "_cfg_wr"}, 32'(cfg_q[i]), 32'(exp_cfg[i]));
    endtask

    // Frame-level reference: expected response and write lists from cmd, len, payload and sent checksum.
    task automatic model_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] sent_chk);
        int x;
        int start;
        bit legal;
        bit good;
        logic [11:0] a;
        x = cmd ^ len;
        foreach (pl[i]) x = x ^ pl[i];
        legal = (cmd == 8'h10 && len >= 2) || (cmd == 8'h20 && len == 2);
        good  = (sent_chk == 8'(x)) && legal;
        exp_resp = good ? 8'h06 : 8'h15;
        if (cmd == 8'h10 && len >= 2) begin
            start = (int'(pl[0]) * 256 + int'(pl[1])) % 4096;
            for (int i = 2; i < len; i++) begin
                a = 12'((start + i - 2) % 4096);
                exp_ram.push_back({a, pl[i]});
            end
        end
        if (good && cmd == 8'h20) exp_cfg.push_back({pl[0][3:0], pl[1]});
    endtask

    typedef struct {
        logic [63:0] bytes;
        int          n;
        logic [7:0]  err;
        logic [7:0]  resp;
        int          nram;
        logic [11:0] a0;
        logic [7:0]  d0;
        logic [11:0] a1;
        logic [7:0]  d1;
        int          ncfg;
        logic [3:0]  cidx;
        logic [7:0]  cdata;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [7:0] b;
        logic [7:0] cmd;
        logic [7:0] len;
        logic [7:0] x;
        logic [7:0] d0;
        int stable;
        int n;

        tbl[0]  = '{64'hA5_20_02_03_7F_5E_00_00, 6, 8'h00, 8'h06, 0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 4'h3, 8'h7F};
        tbl[1]  = '{64'hA5_10_04_00_10_AA_55_FB, 8, 8'h00, 8'h06, 2, 12'h010, 8'hAA, 12'h011, 8'h55, 0, 4'h0, 8'h00};
        tbl[2]  = '{64'hA5_10_04_0F_FF_11_22_D7, 8, 8'h00, 8'h06, 2, 12'hFFF, 8'h11, 12'h000, 8'h22, 0, 4'h0, 8'h00};
        tbl[3]  = '{64'hA5_20_02_03_7F_00_00_00, 6, 8'h00, 8'h15, 0, 12'h000, 8'h00, 12'h000, 8'h00, 0, 4'h0, 8'h00};
        tbl[4]  = '{64'hA5_10_04_00_10_AA_00_00, 6, 8'h20, 8'h15, 0, 12'h000, 8'h00, 12'h000, 8'h00, 0, 4'h0, 8'h00};
        tbl[5]  = '{64'hA5_20_02_03_7F_5E_00_00, 6, 8'h20, 8'h15, 0, 12'h000, 8'h00, 12'h000, 8'h00, 0, 4'h0, 8'h00};
        tbl[6]  = '{64'hA5_33_00_33_00_00_00_00, 4, 8'h00, 8'h15, 0, 12'h000, 8'h00, 12'h000, 8'h00, 0, 4'h0, 8'h00};
        tbl[7]  = '{64'hA5_20_01_05_24_00_00_00, 5, 8'h00, 8'h15, 0, 12'h000, 8'h00, 12'h000, 8'h00, 0, 4'h0, 8'h00};
        tbl[8]  = '{64'hA5_10_02_01_23_30_00_00, 6, 8'h00, 8'h06, 0, 12'h000, 8'h00, 12'h000, 8'h00, 0, 4'h0, 8'h00};
        tbl[9]  = '{64'h5A_A5_20_02_01_09_2A_00, 7, 8'h00, 8'h06, 0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 4'h1, 8'h09};
        tbl[10] = '{64'hA5_A5_20_02_0F_C3_EE_00, 7, 8'h01, 8'h06, 0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 4'hF, 8'hC3};

        reset = 1'b1;
        from_uart_data = 8'h00;
        from_uart_valid = 1'b0;
        from_uart_error = 1'b0;
        to_uart_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_ready", 32'(from_uart_ready), 32'd1);
        chk("rst_valid", 32'(to_uart_valid), 32'd0);
        chk("rst_data", 32'(to_uart_data), 32'd0);
        chk("rst_tx_err", 32'(to_uart_error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram", 32'({ram_we, ram_addr, ram_wdata}), 32'd0);
        chk("rst_cfg", 32'({cfg_we, cfg_idx, cfg_data}), 32'd0);

        for (int v = 0; v < 11; v++) begin
            clear_obs();
            for (int i = 0; i < tbl[v].n; i++) begin
                b = tbl[v].bytes[63 - 8*i -: 8];
                send_byte(b, tbl[v].err[i]);
            end
            exp_resp = tbl[v].resp;
            if (tbl[v].nram > 0) exp_ram.push_back({tbl[v].a0, tbl[v].d0});
            if (tbl[v].nram > 1) exp_ram.push_back({tbl[v].a1, tbl[v].d1});
            if (tbl[v].ncfg > 0) exp_cfg.push_back({tbl[v].cidx, tbl[v].cdata});
            wait_resp($sformatf("vec%0d", v));
            compare_frame($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_idle", v), 32'(busy), 32'd0);
        end

        for (int f = 0; f < 40; f++) begin
            clear_obs();
            pl.delete();
            case ($urandom_range(0, 3))
                0, 1: cmd = 8'h10;
                2: cmd = 8'h20;
                default: cmd = 8'($urandom_range(0, 255));
            endcase
            if (cmd == 8'h20) len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'd2;
            else len = 8'($urandom_range(0, 7));
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
            x = cmd ^ len;
            foreach (pl[i]) x = x ^ pl[i];
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            model_frame(cmd, len, x);
            if ($urandom_range(0, 2) == 0) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                send_byte(b, 1'b0);
            end
            send_byte(8'hA5, 1'b0);
            idle($urandom_range(0, 2));
            send_byte(cmd, 1'b0);
            idle($urandom_range(0, 2));
            send_byte(len, 1'b0);
            foreach (pl[i]) begin
                idle($urandom_range(0, 3));
                send_byte(pl[i], 1'b0);
            end
            send_byte(x, 1'b0);
            wait_resp($sformatf("rnd%0d", f));
            compare_frame($sformatf("rnd%0d", f));
        end

        // Response stall: data and valid held, no byte accepted while waiting.
        clear_obs();
        to_uart_ready = 1'b0;
        send_byte(8'hA5, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0); send_byte(8'h7F, 1'b0); send_byte(8'h5E, 1'b0);
        idle(1);
        n = 0;
        while (!to_uart_valid && n < 20) begin idle(1); n++; end
        d0 = to_uart_data;
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            from_uart_valid = 1'b1;
            from_uart_data = 8'hA5;
            if (to_uart_valid && to_uart_data == d0 && !from_uart_ready) stable++;
        end
        idle(1);
        chk("stall_stable", 32'(stable), 32'd10);
        chk("stall_data", 32'(d0), 32'h06);
        to_uart_ready = 1'b1;
        exp_resp = 8'h06;
        exp_cfg.push_back({4'h3, 8'h7F});
        wait_resp("stall");
        compare_frame("stall");
        chk("stall_idle", 32'(busy), 32'd0);

        // Silent after CMD: NAK exactly TO cycles after the last accepted byte's clock.
        clear_obs();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        n = 0;
        while (!to_uart_valid && n < 3*TO) begin idle(1); n++; end
        chk("timeout_cycles", 32'(n), 32'(TO + 1));
        exp_resp = 8'h15;
        wait_resp("timeout");
        compare_frame("timeout");
        chk("timeout_idle", 32'(busy), 32'd0);

        // A byte arriving on the expiry cycle keeps the frame alive.
        clear_obs();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        idle(TO - 1);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h02, 1'b0);
        exp_resp = 8'h06;
        wait_resp("prio");
        compare_frame("prio");

        // Reset mid-payload: frame dropped, no response, no more writes.
        clear_obs();
        send_byte(8'hA5, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h11, 1'b0);
        @(negedge clk);
        from_uart_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_ready", 32'(from_uart_ready), 32'd1);
        chk("rstmid_valid", 32'(to_uart_valid), 32'd0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        idle(20);
        chk("rstmid_ram_cnt", 32'(ram_q.size()), 32'd1);
        if (ram_q.size() > 0) chk("rstmid_ram_wr", 32'(ram_q[0]), 32'({12'h020, 8'h11}));
        chk("rstmid_resp_cnt", 32'(resp_q.size()), 32'd0);
        chk("rstmid_cfg_cnt", 32'(cfg_q.size()), 32'd0);

        chk("ram_cfg_exclusive", 32'(excl_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
